// File: rtl/segre_pkg.sv
// segre_pkg: shared dcache geometry constants and DMMU responder types
package segre_pkg;
  localparam int DCACHE_NUM_LINES = 4;
  localparam int DCACHE_LANE_SIZE = 128;
  localparam int ADDR_SIZE = 32;
  localparam int DCACHE_BYTE_SIZE = 4;
  localparam int DCACHE_IDX_W = $clog2(DCACHE_NUM_LINES);
  typedef enum logic [1:0] {DMMU_IDLE, DMMU_WB, DMMU_RD, DMMU_RESPOND} dmmu_fsm_state_e;
  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE-1:0] victim_addr;
    logic [DCACHE_LANE_SIZE-1:0] victim_data;
    logic [DCACHE_IDX_W-1:0] index;
  } dmmu_req_t;
endpackage

// File: rtl/segre_lru_tracker.sv
// segre_lru_tracker: true-LRU ages for the dcache lines, oldest line reported as LRU
module segre_lru_tracker
  import segre_pkg::*;
#(
  parameter int NUM_LINES = DCACHE_NUM_LINES,
  parameter int IDX_W = $clog2(NUM_LINES)
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             promote_i,
  input  logic [IDX_W-1:0] promote_idx_i,
  output logic [IDX_W-1:0] lru_index_o
);
  logic [IDX_W-1:0] age_q [NUM_LINES];
  logic [IDX_W-1:0] age_d [NUM_LINES];
  // promoted line becomes youngest; lines younger than it age by one
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++)
      age_d[i] = !promote_i ? age_q[i] :
                 IDX_W'(i) == promote_idx_i ? '0 :
                 age_q[i] < age_q[promote_idx_i] ? age_q[i] + 1'b1 : age_q[i];
  end
  // age registers, reset to the identity permutation
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i)
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= IDX_W'(i);
    else
      for (int i = 0; i < NUM_LINES; i++) age_q[i] <= age_d[i];
  end
  // LRU is the line holding the maximum age
  always_comb begin
    lru_index_o = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (age_q[i] == IDX_W'(NUM_LINES - 1)) lru_index_o = IDX_W'(i);
  end
endmodule

// File: rtl/segre_dmmu_responder.sv
// segre_dmmu_responder: dcache miss/refill responder with dirty-victim writeback
module segre_dmmu_responder
  import segre_pkg::*;
#(
  parameter int NUM_LINES = DCACHE_NUM_LINES,
  parameter int LANE_W = DCACHE_LANE_SIZE,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int OFS_W = DCACHE_BYTE_SIZE,
  localparam int IDX_W = $clog2(NUM_LINES)
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              dc_miss_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_access_i,
  input  logic [IDX_W-1:0]  dc_hit_index_i,
  input  logic              dc_victim_dirty_i,
  input  logic [ADDR_W-1:0] dc_victim_addr_i,
  input  logic [LANE_W-1:0] dc_victim_data_i,
  output logic              dc_data_rdy_o,
  output logic [LANE_W-1:0] dc_data_o,
  output logic [IDX_W-1:0]  dc_lru_index_o,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic              mm_rd_o,
  output logic              mm_wr_o,
  output logic [ADDR_W-1:0] mm_addr_o,
  output logic [LANE_W-1:0] mm_data_o,
  input  logic              mm_rdy_i,
  input  logic [LANE_W-1:0] mm_data_i
);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS_W) - 1);
  dmmu_fsm_state_e state_q, state_d;
  dmmu_req_t req_q;
  logic [ADDR_W-1:0] mm_addr_q, dc_addr_q, line_addr, victim_line;
  logic [LANE_W-1:0] dc_data_q;
  logic skip_q, promote, capture;
  logic [IDX_W-1:0] lru_idx, promote_idx;
  assign line_addr = dc_addr_i & ~OFS_MASK;
  assign victim_line = dc_victim_addr_i & ~OFS_MASK;
  assign capture = state_q == DMMU_IDLE && state_d != DMMU_IDLE;
  assign mm_addr_o = mm_addr_q;
  assign mm_data_o = req_q.victim_data;
  assign dc_data_o = dc_data_q;
  assign dc_addr_o = dc_addr_q;
  segre_lru_tracker #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W)) u_lru (
    .clk_i(clk_i),
    .rsn_i(rsn_i),
    .promote_i(promote),
    .promote_idx_i(promote_idx),
    .lru_index_o(lru_idx)
  );
  // state register
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) state_q <= DMMU_IDLE;
    else state_q <= state_d;
  end
  // next state; a miss right after a response is the stale request and is skipped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMMU_IDLE: if (dc_miss_i && !skip_q) state_d = dc_victim_dirty_i ? DMMU_WB : DMMU_RD;
      DMMU_WB:   if (mm_rdy_i) state_d = DMMU_RD;
      DMMU_RD:   if (mm_rdy_i) state_d = DMMU_RESPOND;
      default:   state_d = DMMU_IDLE;
    endcase
  end
  // outputs decoded from state; the refill slot owns the LRU update while responding
  always_comb begin
    mm_wr_o = state_q == DMMU_WB;
    mm_rd_o = state_q == DMMU_RD;
    dc_data_rdy_o = state_q == DMMU_RESPOND;
    dc_lru_index_o = state_q == DMMU_IDLE ? lru_idx : req_q.index;
    promote = state_q == DMMU_RESPOND || dc_access_i;
    promote_idx = state_q == DMMU_RESPOND ? req_q.index : dc_hit_index_i;
  end
  // request capture, memory address and refill registers
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      req_q <= '0;
      mm_addr_q <= '0;
      dc_addr_q <= '0;
      dc_data_q <= '0;
      skip_q <= 1'b0;
    end else begin
      if (capture) begin
        req_q.addr <= line_addr;
        req_q.index <= lru_idx;
      end
      if (capture && dc_victim_dirty_i) begin
        req_q.victim_addr <= victim_line;
        req_q.victim_data <= dc_victim_data_i;
      end
      if (capture && state_d == DMMU_WB) mm_addr_q <= victim_line;
      else if (state_d == DMMU_RD && state_q != DMMU_RD)
        mm_addr_q <= state_q == DMMU_IDLE ? line_addr : req_q.addr;
      if (state_q == DMMU_RD && mm_rdy_i) begin
        dc_data_q <= mm_data_i;
        dc_addr_q <= req_q.addr;
      end
      skip_q <= state_q == DMMU_RESPOND;
    end
  end
endmodule
